// File: rtl/alsu_mc_pkg.sv
// Shared opcodes, FSM state encoding and flag bundle for the multi-cycle ALU/shift unit.
package alsu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_SHL = 4'h2;
    localparam logic [3:0] OP_SHR = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_INC = 4'h7;
    localparam logic [3:0] OP_ADC = 4'h8;
    localparam logic [3:0] OP_SBC = 4'h9;
    localparam logic [3:0] OP_SAR = 4'hA;
    localparam logic [3:0] OP_OR  = 4'hB;
    localparam logic [3:0] OP_DEC = 4'hC;
    localparam logic [3:0] OP_MUL = 4'hD;
    localparam logic [3:0] OP_CMP = 4'hE;
    localparam logic [3:0] OP_RSV = 4'hF;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    function automatic logic is_shift(input logic [3:0] f);
        return (f == OP_SHL) || (f == OP_SHR) || (f == OP_SAR);
    endfunction

endpackage

// File: rtl/alsu_mc_if.sv
// Operation/result handshake bundle between the register-read stage, the ALU and writeback.
interface alsu_mc_if #(
    parameter int DATAWIDTH = 16,
    parameter int FUNCBITS  = 4
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic [FUNCBITS-1:0]  func;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATAWIDTH-1:0] r;
    logic                 z;
    logic                 n;
    logic                 c;
    logic                 v;
    logic                 err;

    modport master (
        output in_valid, a, b, func, out_ready,
        input  in_ready, out_valid, r, z, n, c, v, err
    );

    modport slave (
        input  in_valid, a, b, func, out_ready,
        output in_ready, out_valid, r, z, n, c, v, err
    );
endinterface

// File: rtl/alsu_mc_core.sv
// Combinational single-cycle datapath: add/sub family, logic ops and one-bit shift step,
// with Z/N/C/V generation. Also serves as the per-iteration shifter for multi-bit shifts.
module alsu_core
    import alsu_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int FUNCBITS  = 4
) (
    input  logic [DATAWIDTH-1:0] a_i,
    input  logic [DATAWIDTH-1:0] b_i,
    input  logic [FUNCBITS-1:0]  func_i,
    input  logic                 c_i,
    input  logic                 shift_en_i,
    output logic [DATAWIDTH-1:0] r_o,
    output flags_t               flags_o
);
    localparam int W = DATAWIDTH;

    logic [W-1:0] bop;
    logic         cin;
    logic         arith;
    logic [W:0]   sum;
    logic [W-1:0] fres;

    always_comb begin
        bop   = '0;
        cin   = 1'b0;
        arith = 1'b0;
        case (func_i)
            OP_ADD:         begin bop = b_i;  arith = 1'b1; end
            OP_SUB, OP_CMP: begin bop = ~b_i; cin = 1'b1; arith = 1'b1; end
            OP_ADC:         begin bop = b_i;  cin = c_i;  arith = 1'b1; end
            OP_SBC:         begin bop = ~b_i; cin = c_i;  arith = 1'b1; end
            OP_INC:         begin cin = 1'b1; arith = 1'b1; end
            OP_DEC:         begin bop = '1;   arith = 1'b1; end
            default:        ;
        endcase
        sum = {1'b0, a_i} + {1'b0, bop} + {{W{1'b0}}, cin};

        r_o     = '0;
        flags_o = '0;
        case (func_i)
            OP_AND: r_o = a_i & b_i;
            OP_OR:  r_o = a_i | b_i;
            OP_XOR: r_o = a_i ^ b_i;
            OP_NOT: r_o = ~a_i;
            OP_CMP: r_o = a_i;
            // A disabled shift step passes A through with C cleared (shift by zero).
            OP_SHL: if (shift_en_i) begin
                        r_o = {a_i[W-2:0], 1'b0};
                        flags_o.c = a_i[W-1];
                    end else r_o = a_i;
            OP_SHR: if (shift_en_i) begin
                        r_o = {1'b0, a_i[W-1:1]};
                        flags_o.c = a_i[0];
                    end else r_o = a_i;
            OP_SAR: if (shift_en_i) begin
                        r_o = {a_i[W-1], a_i[W-1:1]};
                        flags_o.c = a_i[0];
                    end else r_o = a_i;
            default: if (arith) r_o = sum[W-1:0];
        endcase

        if (arith) begin
            flags_o.c = sum[W];
            flags_o.v = (a_i[W-1] == bop[W-1]) && (sum[W-1] != a_i[W-1]);
        end
        // CMP reports the subtraction's Z/N even though it returns A.
        fres      = arith ? sum[W-1:0] : r_o;
        flags_o.z = (fres == '0);
        flags_o.n = fres[W-1];
    end
endmodule

// File: rtl/alsu_mc.sv
// Multi-cycle ALU/shift unit: handshake FSM, iteration counter and flag register.
// Define ALSU_MUL_EN to build the iterative shift-add multiplier (opcode D); otherwise D is illegal.
module alsu_mc
    import alsu_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int FUNCBITS  = 4,
    parameter int SHW       = $clog2(DATAWIDTH)
) (
    input logic        clk_i,
    input logic        rst_n_i,
    alsu_mc_if.slave   bus
);
    localparam int W  = DATAWIDTH;
    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] MUL_STEPS = CW'(DATAWIDTH);

    state_t              state_q;
    logic [FUNCBITS-1:0] func_q;
    logic [W-1:0]        acc_q;
    logic [W-1:0]        r_q;
    logic [CW-1:0]       cnt_q;
    flags_t              flags_q;
    logic                err_q;

    logic                exec, in_ready, accept, is_mul, illegal, multi, mul_op;
    logic [SHW-1:0]      amt;
    logic [FUNCBITS-1:0] cur_func;
    logic [W-1:0]        core_a, core_r, step_r;
    flags_t              core_flags, step_flags;

    assign exec     = (state_q == ST_EXEC);
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign amt      = bus.b[SHW-1:0];
    assign cur_func = exec ? func_q : bus.func;
    assign core_a   = exec ? acc_q : bus.a;

`ifdef ALSU_MUL_EN
    logic [W-1:0] hi_q, mc_q, mul_hi_in, mul_lo_in, mul_mc, mul_hi_next, mul_lo_next;
    logic [W:0]   mul_sum;

    assign is_mul  = (bus.func == OP_MUL);
    assign illegal = (bus.func == OP_RSV);
    assign mul_op  = (cur_func == OP_MUL);

    // One shift-add step; on the accept cycle it starts from hi=0, lo=B, multiplicand=A.
    always_comb begin
        mul_hi_in   = exec ? hi_q : '0;
        mul_lo_in   = exec ? acc_q : bus.b;
        mul_mc      = exec ? mc_q : bus.a;
        mul_sum     = {1'b0, mul_hi_in} + (mul_lo_in[0] ? {1'b0, mul_mc} : {(W+1){1'b0}});
        mul_hi_next = mul_sum[W:1];
        mul_lo_next = {mul_sum[0], mul_lo_in[W-1:1]};
    end

    always_comb begin
        step_r     = core_r;
        step_flags = core_flags;
        if (mul_op) begin
            step_r       = mul_lo_next;
            step_flags.z = (mul_lo_next == '0);
            step_flags.n = mul_lo_next[W-1];
            step_flags.c = |mul_hi_next;
            step_flags.v = 1'b0;
        end
    end
`else
    assign is_mul     = 1'b0;
    assign mul_op     = 1'b0;
    assign illegal    = (bus.func == OP_RSV) || (bus.func == OP_MUL);
    assign step_r     = core_r;
    assign step_flags = core_flags;
`endif

    assign multi = (is_shift(bus.func) && (amt > SHW'(1))) || is_mul;

    alsu_core #(.DATAWIDTH(DATAWIDTH), .FUNCBITS(FUNCBITS)) u_core (
        .a_i        (core_a),
        .b_i        (bus.b),
        .func_i     (cur_func),
        .c_i        (flags_q.c),
        .shift_en_i (exec || (amt != '0)),
        .r_o        (core_r),
        .flags_o    (core_flags)
    );

    // The first iteration of a multi-cycle op runs on the accept edge, so the counter
    // holds the number of iterations still to go.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            func_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
`ifdef ALSU_MUL_EN
            hi_q    <= '0;
            mc_q    <= '0;
`endif
        end else if (accept) begin
            func_q <= bus.func;
            if (illegal) begin
                r_q     <= '0;
                err_q   <= 1'b1;
                state_q <= ST_DONE;
            end else if (multi) begin
                acc_q   <= step_r;
                cnt_q   <= is_mul ? (MUL_STEPS - CW'(1)) : ({1'b0, amt} - CW'(1));
                state_q <= ST_EXEC;
`ifdef ALSU_MUL_EN
                hi_q    <= mul_hi_next;
                mc_q    <= bus.a;
`endif
            end else begin
                r_q     <= core_r;
                flags_q <= core_flags;
                err_q   <= 1'b0;
                state_q <= ST_DONE;
            end
        end else if (exec) begin
            acc_q <= step_r;
`ifdef ALSU_MUL_EN
            hi_q  <= mul_hi_next;
`endif
            if (cnt_q == CW'(1)) begin
                r_q     <= step_r;
                flags_q <= step_flags;
                err_q   <= 1'b0;
                state_q <= ST_DONE;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end else if ((state_q == ST_DONE) && bus.out_ready) begin
            state_q <= ST_IDLE;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.r         = r_q;
    assign bus.z         = flags_q.z;
    assign bus.n         = flags_q.n;
    assign bus.c         = flags_q.c;
    assign bus.v         = flags_q.v;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_alsu_mc.sv
// Directed vector table plus hand sequences for chaining, backpressure and reset abort.
module tb_alsu_mc;
    import alsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alsu_mc_if #(.DATAWIDTH(16), .FUNCBITS(4)) bus ();
    alsu_mc #(.DATAWIDTH(16), .FUNCBITS(4)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic [3:0]  zncv;
        logic        err;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] r, input logic [3:0] zncv, input logic e, input int l);
        vec_t v;
        v.f = f; v.a = a; v.b = b; v.r = r; v.zncv = zncv; v.err = e; v.lat = l;
        vecs.push_back(v);
    endtask

    // Offer one op with OUT_READY low, scramble inputs after accept, return cycles to OUT_VALID.
    task automatic run_op(input logic [3:0] f, input logic [15:0] aa, input logic [15:0] bb,
                          output int lat);
        int guard;
        @(negedge clk);
        bus.func = f; bus.a = aa; bus.b = bb; bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.a = ~aa; bus.b = ~bb; bus.func = OP_ADD;
        lat = 1;
        while (!bus.out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [3:0] fl();
        return {bus.z, bus.n, bus.c, bus.v};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.func = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.out_valid", bus.out_valid, 1'b0);
        check("reset.in_ready", bus.in_ready, 1'b1);
        check("reset.r", bus.r, 16'h0000);
        check("reset.flags", fl(), 4'b0000);
        check("reset.err", bus.err, 1'b0);
        rst_n = 1'b1;

        //       op      A        B        R        ZNCV     ERR  L
        add_vec(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1'b0, 1);
        add_vec(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1'b0, 1);
        add_vec(OP_SUB, 16'h0005, 16'h0007, 16'hFFFE, 4'b0100, 1'b0, 1);
        add_vec(OP_SBC, 16'h0005, 16'h0003, 16'h0001, 4'b0010, 1'b0, 1);
        add_vec(OP_ADC, 16'h0001, 16'h0001, 16'h0003, 4'b0000, 1'b0, 1);
        add_vec(OP_SHL, 16'h8001, 16'h0004, 16'h0010, 4'b0000, 1'b0, 4);
        add_vec(OP_SHR, 16'h0009, 16'h0004, 16'h0000, 4'b1010, 1'b0, 4);
        add_vec(OP_SAR, 16'h8000, 16'h0003, 16'hF000, 4'b0100, 1'b0, 3);
        add_vec(OP_SHL, 16'h1234, 16'h0000, 16'h1234, 4'b0000, 1'b0, 1);
        add_vec(OP_SHR, 16'h0003, 16'h0001, 16'h0001, 4'b0010, 1'b0, 1);
        add_vec(OP_RSV, 16'h1234, 16'h0001, 16'h0000, 4'b0010, 1'b1, 1);
        add_vec(OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000, 1'b0, 1);
        add_vec(OP_XOR, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000, 1'b0, 1);
        add_vec(OP_NOT, 16'h0000, 16'h0000, 16'hFFFF, 4'b0100, 1'b0, 1);
        add_vec(OP_INC, 16'h7FFF, 16'h0000, 16'h8000, 4'b0101, 1'b0, 1);
        add_vec(OP_DEC, 16'h0000, 16'h0000, 16'hFFFF, 4'b0100, 1'b0, 1);
        add_vec(OP_CMP, 16'h0005, 16'h0003, 16'h0005, 4'b0010, 1'b0, 1);
        add_vec(OP_OR,  16'h1200, 16'h0034, 16'h1234, 4'b0000, 1'b0, 1);
        add_vec(OP_SHL, 16'h0001, 16'h000F, 16'h8000, 4'b0100, 1'b0, 15);
`ifdef ALSU_MUL_EN
        add_vec(OP_MUL, 16'h0100, 16'h0100, 16'h0000, 4'b1010, 1'b0, 16);
        add_vec(OP_MUL, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 1'b0, 16);
`else
        add_vec(OP_MUL, 16'h0100, 16'h0100, 16'h0000, 4'b0100, 1'b1, 1);
`endif
        add_vec(OP_SHL, 16'h0001, 16'h0010, 16'h0001, 4'b0000, 1'b0, 1);

        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, lat);
            $display("vec %0d op=%h a=%h b=%h -> r=%h zncv=%b err=%b lat=%0d",
                     i, vecs[i].f, vecs[i].a, vecs[i].b, bus.r, fl(), bus.err, lat);
            check($sformatf("v%0d.lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d.r", i), bus.r, vecs[i].r);
            check($sformatf("v%0d.zncv", i), fl(), vecs[i].zncv);
            check($sformatf("v%0d.err", i), bus.err, vecs[i].err);
            consume();
        end

        // Back-to-back ADD then ADC with OUT_READY high: carry chains across the handoff.
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.func = OP_ADD; bus.a = 16'hFFFF; bus.b = 16'h0001; bus.in_valid = 1'b1;
        @(negedge clk);
        $display("chain add -> r=%h c=%b", bus.r, bus.c);
        check("chain1.out_valid", bus.out_valid, 1'b1);
        check("chain1.r", bus.r, 16'h0000);
        check("chain1.c", bus.c, 1'b1);
        check("chain1.in_ready", bus.in_ready, 1'b1);
        bus.func = OP_ADC; bus.a = 16'h0000; bus.b = 16'h0000;
        @(negedge clk);
        $display("chain adc -> r=%h c=%b", bus.r, bus.c);
        check("chain2.out_valid", bus.out_valid, 1'b1);
        check("chain2.r", bus.r, 16'h0001);
        check("chain2.c", bus.c, 1'b0);
        bus.func = OP_ADD; bus.a = 16'h0002; bus.b = 16'h0003;
        @(negedge clk);
        $display("chain add3 -> r=%h", bus.r);
        check("chain3.r", bus.r, 16'h0005);
        check("chain3.out_valid", bus.out_valid, 1'b1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("chain.drained", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;

        // Backpressure: result must hold while OUT_READY is low.
        run_op(OP_SHL, 16'h8001, 16'h0004, lat);
        $display("bp shl -> r=%h lat=%0d", bus.r, lat);
        check("bp.lat", lat, 4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d.r", k), bus.r, 16'h0010);
            check($sformatf("bp%0d.zncv", k), fl(), 4'b0000);
            check($sformatf("bp%0d.out_valid", k), bus.out_valid, 1'b1);
            check($sformatf("bp%0d.in_ready", k), bus.in_ready, 1'b0);
        end
        bus.func = OP_ADD; bus.a = 16'h0002; bus.b = 16'h0003; bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("bp.in_ready_comb", bus.in_ready, 1'b1);
        @(negedge clk);
        $display("bp add -> r=%h", bus.r);
        bus.in_valid = 1'b0;
        check("bp.new_r", bus.r, 16'h0005);
        check("bp.new_valid", bus.out_valid, 1'b1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp.drained", bus.out_valid, 1'b0);

        // Reset abort at iteration 5 of a long multi-cycle op.
        @(negedge clk);
`ifdef ALSU_MUL_EN
        bus.func = OP_MUL; bus.a = 16'h0100; bus.b = 16'h0100;
`else
        bus.func = OP_SHL; bus.a = 16'h0001; bus.b = 16'h000F;
`endif
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort.busy", bus.out_valid, 1'b0);
        rst_n = 1'b0;
        #1;
        $display("abort -> r=%h out_valid=%b in_ready=%b", bus.r, bus.out_valid, bus.in_ready);
        check("abort.out_valid", bus.out_valid, 1'b0);
        check("abort.r", bus.r, 16'h0000);
        check("abort.in_ready", bus.in_ready, 1'b1);
        check("abort.zncv", fl(), 4'b0000);
        check("abort.err", bus.err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_ADD, 16'h0001, 16'h0001, lat);
        $display("post-reset add -> r=%h lat=%0d", bus.r, lat);
        check("post.lat", lat, 1);
        check("post.r", bus.r, 16'h0002);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
